vm_operand_loader: RTL



---
 rtl/vm_operand_loader_pkg.sv | 24 ++
 rtl/vm_operand_loader_if.sv | 27 ++
 rtl/vm_operand_loader_debounce.sv | 46 ++++
 rtl/vm_operand_loader.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/vm_operand_loader_pkg.sv
// Shared types and defaults for the vedic-multiplier operand loader.
// Optional LED echo outputs are enabled by defining VM_LOADER_LED_ECHO_EN.
package vm_loader_pkg;

  localparam int DEFAULT_WIDTH           = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_e;

  // Encoding shown on the phase LEDs; 00 is reserved for "in reset".
  function automatic logic [1:0] phase_code(state_e s);
    case (s)
      LOAD_A:  phase_code = 2'b01;
      LOAD_B:  phase_code = 2'b10;
      PRESENT: phase_code = 2'b11;
      default: phase_code = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/vm_operand_loader_if.sv
// Operand handoff bus between the loader (master) and the multiplier (slave).
interface vm_operand_loader_if
  import vm_loader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] op_a_o;
  logic [WIDTH-1:0] op_b_o;
  logic             op_valid_o;
  logic             op_ready_i;

  modport master (
    output op_a_o,
    output op_b_o,
    output op_valid_o,
    input  op_ready_i
  );

  modport slave (
    input  op_a_o,
    input  op_b_o,
    input  op_valid_o,
    output op_ready_i
  );

endinterface

// File: rtl/vm_operand_loader_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for one raw board input.
module vm_debounce
  import vm_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_deb
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic [CW-1:0] r_cnt;

  // NOTE: non-blocking assignments make r_sync2 take the old r_sync1, giving a
  // true two-stage chain; blocking here would collapse it into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_deb = r_deb;

endmodule

// File: rtl/vm_operand_loader.sv
// Bit-serial operand entry (MSB first, A then B) from a switch and enter button.
// Defining VM_LOADER_LED_ECHO_EN adds led_echo_o / led_phase_o.
module vm_operand_loader
  import vm_loader_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sw_bit_i,
  input  logic                       btn_enter_i,
  vm_operand_loader_if.master        op_if,
  output logic                       busy_o,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt_o
`ifdef VM_LOADER_LED_ECHO_EN
  ,
  output logic [WIDTH-1:0]           led_echo_o,
  output logic [1:0]                 led_phase_o
`endif
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic             w_sw_deb;
  logic             w_btn_deb;
  logic             w_press;
  logic             r_btn_prev;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] w_op_a_nxt;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] w_op_b_nxt;
  logic [CW-1:0]    r_bit_cnt;
  logic [CW-1:0]    w_bit_cnt_nxt;

  vm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_raw (sw_bit_i),
    .o_deb (w_sw_deb)
  );

  vm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_raw (btn_enter_i),
    .o_deb (w_btn_deb)
  );

  assign w_press = w_btn_deb & ~r_btn_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_prev <= 1'b0;
      r_state    <= LOAD_A;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_btn_prev <= w_btn_deb;
      r_state    <= w_state_nxt;
      r_op_a     <= w_op_a_nxt;
      r_op_b     <= w_op_b_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
    end
  end

  // NOTE: every output of this block is given a hold value first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_op_a_nxt    = r_op_a;
    w_op_b_nxt    = r_op_b;
    w_bit_cnt_nxt = r_bit_cnt;
    case (r_state)
      LOAD_A: begin
        if (w_press) begin
          w_op_a_nxt = {r_op_a[WIDTH-2:0], w_sw_deb};
          if (r_bit_cnt == CNT_LAST) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = LOAD_B;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + CW'(1);
          end
        end
      end
      LOAD_B: begin
        if (w_press) begin
          w_op_b_nxt = {r_op_b[WIDTH-2:0], w_sw_deb};
          if (r_bit_cnt == CNT_LAST) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = PRESENT;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + CW'(1);
          end
        end
      end
      PRESENT: begin
        // Presses are dropped here, including one coinciding with the handshake.
        if (op_if.op_ready_i) begin
          w_op_a_nxt    = '0;
          w_op_b_nxt    = '0;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = LOAD_A;
        end
      end
      default: begin
        w_state_nxt = LOAD_A;
      end
    endcase
  end

  assign op_if.op_a_o     = r_op_a;
  assign op_if.op_b_o     = r_op_b;
  assign op_if.op_valid_o = (r_state == PRESENT);
  assign busy_o           = (r_state == LOAD_B) ||
                            ((r_state == LOAD_A) && (r_bit_cnt != '0));
  assign bit_cnt_o        = r_bit_cnt;

`ifdef VM_LOADER_LED_ECHO_EN
  logic [WIDTH-1:0] r_led_echo;
  logic [1:0]       r_led_phase;

  // Registered from next-state values so the LEDs line up with op_a/op_b.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led_echo  <= '0;
      r_led_phase <= 2'b00;
    end else begin
      r_led_echo  <= (w_state_nxt == LOAD_B) ? w_op_b_nxt : w_op_a_nxt;
      r_led_phase <= phase_code(w_state_nxt);
    end
  end

  assign led_echo_o  = r_led_echo;
  assign led_phase_o = r_led_phase;
`else
  // Echo LEDs are not built; the loader exposes only the operand bus.
`endif

endmodule
